// File: rtl/data_mem_ctrl_if.sv
// Processor and host access bundle for data_mem_ctrl.
// The master side drives the requests and the slave side is the controller.
interface data_mem_ctrl_if;
  logic        dm_en;
  logic        dm_we;
  logic [15:0] ar_in;
  logic [7:0]  bus_in;
  logic [7:0]  dm_out;
  logic [1:0]  status;
  logic        end_process;
  logic        host_start;
  logic        host_done;
  logic        host_en;
  logic        host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        host_valid;
  logic        addr_err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  modport master (
    output dm_en, dm_we, ar_in, bus_in, end_process,
    output host_start, host_done, host_en, host_we, host_addr, host_wdata,
    input  dm_out, status, host_rdata, host_valid, addr_err, rd_cnt, wr_cnt
  );

  modport slave (
    input  dm_en, dm_we, ar_in, bus_in, end_process,
    input  host_start, host_done, host_en, host_we, host_addr, host_wdata,
    output dm_out, status, host_rdata, host_valid, addr_err, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-wide data memory shared by a host (LOAD/DUMP phases) and a processor (RUN phase).
// Define DMEM_ACCESS_CNT_EN to build the saturating processor read/write counters.
module data_mem_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int INIT_ZERO = 1
) (
  input  logic            clock,
  input  logic            rst_r,
  data_mem_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DUMP = 2'b11
  } state_t;

  state_t state, state_nx;

  logic              sweep_act;
  logic              done_pend;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_last;
  logic              load_entry;

  logic              proc_act, proc_oor;
  logic              host_act, host_wr, host_oor;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;

  logic [7:0] mem [DEPTH];

  assign sweep_last = sweep_act && (&sweep_addr);
  assign load_entry = (state == IDLE) && (state_nx == LOAD);

  always_ff @(posedge clock or negedge rst_r) begin
    if (!rst_r) state <= IDLE;
    else        state <= state_nx;
  end

  // host_done seen mid-sweep is remembered and honoured on the last sweep cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.host_start) state_nx = LOAD;
      LOAD: begin
        if (!sweep_act) begin
          if (bus.host_done) state_nx = RUN;
        end else if (sweep_last && (done_pend || bus.host_done)) begin
          state_nx = RUN;
        end
      end
      RUN:  if (bus.end_process) state_nx = DUMP;
      DUMP: if (bus.host_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.status = state;

  always_ff @(posedge clock or negedge rst_r) begin
    if (!rst_r) begin
      sweep_act  <= 1'b0;
      done_pend  <= 1'b0;
      sweep_addr <= '0;
    end else if (load_entry && (INIT_ZERO != 0)) begin
      sweep_act  <= 1'b1;
      done_pend  <= 1'b0;
      sweep_addr <= '0;
    end else if (sweep_act) begin
      sweep_addr <= sweep_addr + 1'b1;
      if (sweep_last) begin
        sweep_act <= 1'b0;
        done_pend <= 1'b0;
      end else if (bus.host_done) begin
        done_pend <= 1'b1;
      end
    end
  end

  // Access decode: the sweep owns the array, then RUN gives it to the processor,
  // LOAD/DUMP to the host; DUMP accesses are reads whatever host_we says.
  always_comb begin
    proc_act = (state == RUN) && bus.dm_en;
    proc_oor = |bus.ar_in[15:ADDR_W];
    host_act = bus.host_en && !sweep_act && ((state == LOAD) || (state == DUMP));
    host_wr  = host_act && bus.host_we && (state == LOAD);
    host_oor = |bus.host_addr[15:ADDR_W];

    mem_we    = 1'b0;
    mem_waddr = sweep_addr;
    mem_wdata = 8'h00;
    if (sweep_act) begin
      mem_we = 1'b1;
    end else if (proc_act && bus.dm_we && !proc_oor) begin
      mem_we    = 1'b1;
      mem_waddr = bus.ar_in[ADDR_W-1:0];
      mem_wdata = bus.bus_in;
    end else if (host_wr && !host_oor) begin
      mem_we    = 1'b1;
      mem_waddr = bus.host_addr[ADDR_W-1:0];
      mem_wdata = bus.host_wdata;
    end

    mem_raddr = (state == RUN) ? bus.ar_in[ADDR_W-1:0] : bus.host_addr[ADDR_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read stage: one cycle from sampled access to returned byte
  always_ff @(posedge clock or negedge rst_r) begin
    if (!rst_r) begin
      bus.dm_out     <= 8'h00;
      bus.host_rdata <= 8'h00;
      bus.host_valid <= 1'b0;
      bus.addr_err   <= 1'b0;
    end else begin
      if (proc_act) begin
        if (proc_oor) begin
          if (!bus.dm_we) bus.dm_out <= 8'h00;
        end else if (bus.dm_we) begin
          bus.dm_out <= bus.bus_in;
        end else begin
          bus.dm_out <= mem[mem_raddr];
        end
      end
      bus.host_valid <= host_act && !host_wr;
      if (host_act && !host_wr)
        bus.host_rdata <= host_oor ? 8'h00 : mem[mem_raddr];
      if ((proc_act && proc_oor) || (host_act && host_oor))
        bus.addr_err <= 1'b1;
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock or negedge rst_r) begin
    if (!rst_r) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else if ((state != RUN) && (state_nx == RUN)) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else if (proc_act) begin
      if (bus.dm_we) wr_cnt_q <= sat_inc(wr_cnt_q);
      else           rd_cnt_q <= sat_inc(rd_cnt_q);
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
  assign bus.wr_cnt = wr_cnt_q;
`else
  assign bus.rd_cnt = 16'd0;
  assign bus.wr_cnt = 16'd0;
`endif

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the implemented address bits, giving DEPTH = 2^ADDR_W bytes.
REQ-002 Parameter INIT_ZERO, default 1, SHALL clear the whole array on entry to LOAD when 1.
REQ-003 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_r, input, 1: reset, asynchronous and active-low.
REQ-005 Port dm_en, input, 1: processor access strobe.
REQ-006 Port dm_we, input, 1: processor write qualifier, valid with dm_en.
REQ-007 Port ar_in, input, 16: processor byte address.
REQ-008 Port bus_in, input, 8: processor write data.
REQ-009 Port dm_out, output, 8: registered read data to the processor.
REQ-010 Port status, output, 2: phase code to the processor (00 IDLE, 01 LOAD, 10 RUN, 11 DUMP).
REQ-011 Port end_process, input, 1: processor completion pulse or level.
REQ-012 Port host_start, input, 1: host request to leave IDLE.
REQ-013 Port host_done, input, 1: host signals the end of the LOAD or DUMP phase.
REQ-014 Port host_en, input, 1: host access strobe.
REQ-015 Port host_we, input, 1: host write qualifier.
REQ-016 Port host_addr, input, 16: host byte address.
REQ-017 Port host_wdata, input, 8: host write data.
REQ-018 Port host_rdata, output, 8: registered host read data.
REQ-019 Port host_valid, output, 1: host_rdata valid for one cycle.
REQ-020 Port addr_err, output, 1: sticky out-of-range flag.
REQ-021 Port rd_cnt, output, 16: processor read count.
REQ-022 Port wr_cnt, output, 16: processor write count.

Function
REQ-023 The FSM SHALL have four states: IDLE, LOAD, RUN and DUMP, and status SHALL equal the current-state code, registered.
REQ-024 The FSM SHALL make these transitions:
- IDLE to LOAD on host_start.
- LOAD to RUN on host_done.
- RUN to DUMP on end_process.
- DUMP to IDLE on host_done.
- All other inputs hold the current state.
REQ-025 If INIT_ZERO=1, LOAD entry SHALL sweep-clear the array at one byte per cycle (DEPTH cycles) with host access stalled; host_done during the sweep SHALL be deferred until the sweep completes.
REQ-026 The processor port SHALL be active only in RUN; dm_en outside RUN SHALL be ignored, and dm_out SHALL hold its value.
REQ-027 The host port SHALL be active only in LOAD (read/write) and DUMP (read only); host_we in DUMP SHALL be ignored.
REQ-028 Read latency SHALL be 1 cycle: an access at edge N SHALL present its data on dm_out or host_rdata after edge N+1, and host_valid SHALL pulse at N+1.
REQ-029 A processor write (dm_en & dm_we) SHALL store bus_in at the addressed location and SHALL also drive bus_in onto dm_out (write-through).
REQ-030 Back-to-back accesses every cycle SHALL be supported with no bubbles.
REQ-031 A write followed by a read of the same address on the next cycle SHALL return the new data.
REQ-032 An access with any of ar_in/host_addr[15:ADDR_W] nonzero SHALL be treated as out of range:
- A read returns 8'h00.
- A write is dropped.
- addr_err is set and held until reset.
REQ-033 If host_start and host_done are both asserted in IDLE, only host_start SHALL take effect.
REQ-034 If end_process is asserted in a cycle with a processor write, that write SHALL complete before the move to DUMP.

Reset
REQ-035 Asserting rst_r low SHALL immediately force:
- state=IDLE, status=00
- dm_out=0, host_rdata=0, host_valid=0
- addr_err=0, rd_cnt=0, wr_cnt=0
- Array contents are not reset.
REQ-036 Reset asserted mid-sweep or mid-RUN SHALL abort the operation, and deassertion SHALL resume in IDLE.

Configuration
REQ-037 When macro DMEM_ACCESS_CNT_EN is defined, rd_cnt and wr_cnt SHALL count processor reads and writes accepted in RUN, saturating at 16'hFFFF and clearing on entry to RUN.
REQ-038 When DMEM_ACCESS_CNT_EN is undefined, rd_cnt and wr_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-039 Reset then host_start, LOAD writes 8'hA5 to 0x010, then host_done: status goes 00->01->10, and a RUN read of 0x010 gives dm_out=8'hA5 one cycle later.
REQ-040 In RUN, write 8'h3C to 0x020 then read 0x020 on the next cycle: dm_out=8'h3C on both cycles.
REQ-041 Read address 0x1000 with ADDR_W=12: dm_out=8'h00, addr_err=1 and stays 1 until reset.
REQ-042 end_process together with a write of 8'h77 to 0x005: status=11, and a DUMP host read of 0x005 gives host_rdata=8'h77 with host_valid high for 1 cycle.
REQ-043 rst_r pulsed low mid-RUN: status=00 and dm_out=0 asynchronously; the DMEM_ACCESS_CNT_EN build shows rd_cnt=0 after 3 reads when reset is applied, and the non-EN build keeps rd_cnt=0 throughout.
